dmem_responder: RTL and testbench

//  Data-memory responder for the CPU MEM stage: services load/store requests through a
//  req/ack handshake with a fixed, parameterised access latency, and drives a stall

---
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Bus bundle between the MEM stage (master) and the data-memory responder
// (slave).
//
// Master drives: req, we, addr (byte address), wdata.
// Slave drives:  ack (one-cycle completion pulse), rdata (load data),
//                err (qualifies ack), stall (pipeline freeze request).
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        err;
    logic        stall;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata, err, stall
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata, err, stall
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU MEM stage.
//
// It accepts one load or store at a time over a req/ack handshake. Each access
// completes a fixed LATENCY cycles after it is captured. While an access is
// pending, stall asks the pipeline to hold PC and the pipeline registers.
// The storage is word-addressed. An access that is misaligned or outside the
// array still completes, but with err set.
//
// Ports:
//   clk_i  - clock; all state changes on the rising edge
//   rst_i  - synchronous reset, active-low; storage contents are kept
//   bus    - dmem_responder_if.slave:
//            req/we/addr/wdata in; ack/rdata/err/stall out
//
// Parameters:
//   DEPTH_WORDS - number of 32-bit words stored (power of two, >= 2)
//   LATENCY     - cycles from request capture to ack (1..15)
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dmem_responder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [30:0] DEPTH_W  = 31'(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_reg;
    logic [3:0]      count_reg;
    logic            we_reg;
    logic            err_reg;
    logic [AW-1:0]   idx_reg;
    logic [31:0]     wdata_reg;
    logic            ack_reg;
    logic            err_out_reg;
    logic            rdata_zero_reg;
    logic [31:0]     mem_q_reg;

    logic [31:0]     mem [DEPTH_WORDS];

    // Decode of the address currently on the bus (used at capture).
    logic            bus_err;
    assign bus_err = (bus.addr[1:0] != 2'b00) || ({1'b0, bus.addr[31:2]} >= DEPTH_W);

    // The access entering RESP at this edge.
    // With LATENCY=1 it enters straight from IDLE, so its attributes come
    // from the bus. Otherwise they come from the captured copy.
    logic            in_idle;
    logic            enter_resp;
    logic            cur_we;
    logic            cur_err;
    logic [AW-1:0]   cur_idx;
    logic            rd_en;
    logic            wr_en;

    assign in_idle    = (state_reg == IDLE);
    assign enter_resp = (in_idle && bus.req && (LATENCY == 1)) ||
                        (state_reg == WAIT && count_reg == 4'd0);
    assign cur_we     = in_idle ? bus.we : we_reg;
    assign cur_err    = in_idle ? bus_err : err_reg;
    assign cur_idx    = in_idle ? bus.addr[AW+1:2] : idx_reg;

    // The read fires on the edge entering RESP. The write fires on the edge
    // leaving RESP, so a read and a write never share an edge.
    // A reset on that edge aborts the store.
    assign rd_en = rst_i && enter_resp && !cur_we && !cur_err;
    assign wr_en = rst_i && (state_reg == RESP) && we_reg && !err_reg;

    // Storage is not reset, so that it maps onto block RAM with a registered read.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[idx_reg] <= wdata_reg;
        end
        if (rd_en) begin
            mem_q_reg <= mem[cur_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg      <= IDLE;
            count_reg      <= 4'd0;
            ack_reg        <= 1'b0;
            err_out_reg    <= 1'b0;
            rdata_zero_reg <= 1'b1;
        end else begin
            ack_reg     <= 1'b0;
            err_out_reg <= 1'b0;
            // rdata changes only when a new access reaches RESP.
            // Otherwise it holds its previous value.
            if (enter_resp) begin
                rdata_zero_reg <= !rd_en;
            end
            case (state_reg)
                IDLE: begin
                    if (bus.req) begin
                        we_reg    <= bus.we;
                        err_reg   <= bus_err;
                        idx_reg   <= bus.addr[AW+1:2];
                        wdata_reg <= bus.wdata;
                        if (LATENCY == 1) begin
                            state_reg   <= RESP;
                            ack_reg     <= 1'b1;
                            err_out_reg <= bus_err;
                        end else begin
                            state_reg <= WAIT;
                            count_reg <= LAT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (count_reg == 4'd0) begin
                        state_reg   <= RESP;
                        ack_reg     <= 1'b1;
                        err_out_reg <= err_reg;
                    end else begin
                        count_reg <= count_reg - 4'd1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack   = ack_reg;
    assign bus.err   = err_out_reg;
    assign bus.rdata = rdata_zero_reg ? 32'd0 : mem_q_reg;

    // Stall drops in the ack cycle, so the pipeline advances exactly on ack.
    assign bus.stall = (bus.req && (state_reg != RESP)) || (state_reg == WAIT);
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    dmem_responder_if bus3 ();
    dmem_responder_if bus1 ();

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u3 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus3)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u1 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    // Behavioural reference memory for the random phase.
    logic [31:0] ref_mem   [256];
    bit          ref_valid [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel) begin
            bus1.req = req; bus1.we = we; bus1.addr = addr; bus1.wdata = wdata;
        end else begin
            bus3.req = req; bus3.we = we; bus3.addr = addr; bus3.wdata = wdata;
        end
    endtask

    function automatic logic get_ack(input bit sel);
        return sel ? bus1.ack : bus3.ack;
    endfunction
    function automatic logic get_stall(input bit sel);
        return sel ? bus1.stall : bus3.stall;
    endfunction

    // Precondition: DUT idle, time is just after a rising edge.
    // Returns with the DUT idle again, just after a rising edge.
    // lat is the number of edges from capture to the ack cycle (capture edge = 1).
    task automatic access(input bit sel, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output int stall_cnt,
                          output logic ack_stall, output logic err, output logic [31:0] rdata);
        bit got;
        lat = 0; stall_cnt = 0; ack_stall = 1'b1; err = 1'b0; rdata = 32'd0; got = 0;
        drive(sel, 1'b1, we, addr, wdata);
        #1;
        if (get_stall(sel)) stall_cnt++;
        while (lat < 20 && !got) begin
            @(posedge clk); #1;
            lat++;
            if (get_ack(sel)) begin
                got       = 1;
                ack_stall = get_stall(sel);
                err       = sel ? bus1.err : bus3.err;
                rdata     = sel ? bus1.rdata : bus3.rdata;
            end else if (get_stall(sel)) begin
                stall_cnt++;
            end
        end
        if (!got) lat = -1;
        drive(sel, 1'b0, we, addr, wdata);
        $display("txn dut=L%0d %s addr=%h wdata=%h lat=%0d err=%0b rdata=%h",
                 sel ? 1 : 3, we ? "ST" : "LD", addr, wdata, lat, err, rdata);
        @(posedge clk); #1;
    endtask

    vec_t        vecs [11];
    int          lat, scnt, acks, op, last_ack;
    logic        astall, err;
    logic [31:0] rdata;
    logic [31:0] b2b_exp [4];
    bit          got;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack3",   32'(bus3.ack),   32'd0);
        check("rst_err3",   32'(bus3.err),   32'd0);
        check("rst_rdata3", bus3.rdata,      32'd0);
        check("rst_stall3", 32'(bus3.stall), 32'd0);
        check("rst_ack1",   32'(bus1.ack),   32'd0);
        check("rst_rdata1", bus1.rdata,      32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table: basic function and error boundaries (LATENCY=3).
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'h0};
        vecs[4]  = '{1'b1, 32'h0000_0400, 32'h0000_0BAD, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678};
        vecs[6]  = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'hCAFE_F00D};
        vecs[8]  = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0};
        vecs[9]  = '{1'b1, 32'h0000_0011, 32'h5555_5555, 1'b1, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        for (int i = 0; i < 11; i++) begin
            access(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, scnt, astall, err, rdata);
            check($sformatf("vec%0d_lat", i),   32'(lat),    32'd3);
            check($sformatf("vec%0d_err", i),   32'(err),    32'(vecs[i].exp_err));
            check($sformatf("vec%0d_rdata", i), rdata,       vecs[i].exp_rdata);
            check($sformatf("vec%0d_stall", i), 32'(scnt),   32'd3);
            check($sformatf("vec%0d_ackstall", i), 32'(astall), 32'd0);
            check($sformatf("vec%0d_hold", i),  bus3.rdata,  vecs[i].exp_rdata);
        end

        // Back-to-back with req held high: acks every 4 cycles, stall = ~ack.
        b2b_exp[0] = 32'h0; b2b_exp[1] = 32'h1111_1111;
        b2b_exp[2] = 32'h0; b2b_exp[3] = 32'h2222_2222;
        drive(0, 1'b1, 1'b1, 32'h20, 32'h1111_1111);
        op = 0; last_ack = 0;
        for (int cyc = 1; cyc <= 40 && op < 4; cyc++) begin
            @(posedge clk); #1;
            if (bus3.ack) begin
                check("b2b_spacing", 32'(cyc - last_ack), (op == 0) ? 32'd3 : 32'd4);
                check("b2b_rdata", bus3.rdata, b2b_exp[op]);
                check("b2b_stall_ack", 32'(bus3.stall), 32'd0);
                last_ack = cyc;
                op++;
                case (op)
                    1: drive(0, 1'b1, 1'b0, 32'h20, 32'h0);
                    2: drive(0, 1'b1, 1'b1, 32'h20, 32'h2222_2222);
                    3: drive(0, 1'b1, 1'b0, 32'h20, 32'h0);
                    default: drive(0, 1'b0, 1'b0, 32'h20, 32'h0);
                endcase
            end else begin
                check("b2b_stall", 32'(bus3.stall), 32'd1);
            end
        end
        check("b2b_done", 32'(op), 32'd4);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;

        // Reset during WAIT aborts the store.
        access(0, 1'b1, 32'h30, 32'h1, lat, scnt, astall, err, rdata);
        drive(0, 1'b1, 1'b1, 32'h30, 32'h99);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rstw_ack", 32'(bus3.ack), 32'd0);
        check("rstw_rdata", bus3.rdata, 32'd0);
        acks = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus3.ack) acks++;
        end
        check("rstw_noack", 32'(acks), 32'd0);
        access(0, 1'b0, 32'h30, 32'h0, lat, scnt, astall, err, rdata);
        check("rstw_keep", rdata, 32'h1);

        // Bus changes during WAIT are ignored.
        access(0, 1'b1, 32'hC, 32'h5, lat, scnt, astall, err, rdata);
        drive(0, 1'b1, 1'b1, 32'h8, 32'hA);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'hC, 32'hB);
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(posedge clk); #1;
            if (bus3.ack) got = 1;
        end
        check("chg_ack", 32'(got), 32'd1);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        access(0, 1'b0, 32'h8, 32'h0, lat, scnt, astall, err, rdata);
        check("chg_word8", rdata, 32'hA);
        access(0, 1'b0, 32'hC, 32'h0, lat, scnt, astall, err, rdata);
        check("chg_wordC", rdata, 32'h5);

        // LATENCY=1 instance.
        access(1, 1'b1, 32'h4, 32'h44, lat, scnt, astall, err, rdata);
        check("l1_st_lat", 32'(lat), 32'd1);
        check("l1_st_stall", 32'(scnt), 32'd1);
        access(1, 1'b0, 32'h4, 32'h0, lat, scnt, astall, err, rdata);
        check("l1_ld_lat", 32'(lat), 32'd1);
        check("l1_ld_rdata", rdata, 32'h44);
        check("l1_ld_err", 32'(err), 32'd0);
        check("l1_ld_stall", 32'(scnt), 32'd1);
        check("l1_ld_ackstall", 32'(astall), 32'd0);
        access(1, 1'b0, 32'h6, 32'h0, lat, scnt, astall, err, rdata);
        check("l1_mis_err", 32'(err), 32'd1);
        check("l1_mis_rdata", rdata, 32'd0);

        // Random accesses against the reference model.
        for (int w = 0; w < 256; w++) ref_valid[w] = 0;
        for (int i = 0; i < 150; i++) begin
            bit          r_we;
            int unsigned kind, w;
            logic [31:0] a, d;
            bit          e;
            r_we = 1'($urandom_range(0, 1));
            w    = $urandom_range(0, 31);
            kind = $urandom_range(0, 7);
            d    = $urandom();
            a    = w * 4;
            if (kind == 0) a = a + $urandom_range(1, 3);
            if (kind == 1) a = (256 + $urandom_range(0, 1000)) * 4;
            if (kind == 2) a = $urandom() & 32'hFFFF_FFFC;
            e = (a % 4 != 0) || (a / 4 >= 256);
            access(0, r_we, a, d, lat, scnt, astall, err, rdata);
            check("rnd_lat", 32'(lat), 32'd3);
            check("rnd_err", 32'(err), 32'(e));
            check("rnd_stall", 32'(scnt), 32'd3);
            if (r_we || e) begin
                check("rnd_rdata_zero", rdata, 32'd0);
            end else if (ref_valid[a / 4]) begin
                check("rnd_rdata", rdata, ref_mem[a / 4]);
            end
            if (r_we && !e) begin
                ref_mem[a / 4]   = d;
                ref_valid[a / 4] = 1;
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
